edlo_input_conditioner: RTL and testbench

// - Upstream stage of tt_um_venom_edlo: conditions the raw ui_in pins before the core logic sees them.
// - Per bit: 2-flop synchroniser, then a tick-sampled debouncer.
// - Each debounced level change becomes an {polarity, bit index} event.
// - Events queue in a small FIFO and are handed to the core over valid/ready.

---
 rtl/edlo_pkg.sv | 18 +
 rtl/edlo_evt_fifo.sv | 51 +++++
 rtl/edlo_input_conditioner.sv | 145 ++++++++++++++
 tb/tb_edlo_input_conditioner.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edlo_pkg.sv
// Shared types and default timing constants for the edlo input path and core.
// Latency: n/a (types only).
// Backpressure: n/a.
package edlo_pkg;

    localparam int EDLO_WIDTH      = 8;
    localparam int EDLO_PRESCALE   = 16;
    localparam int EDLO_DB_CYCLES  = 4;
    localparam int EDLO_FIFO_DEPTH = 4;

    localparam int EVT_IDX_W = $clog2(EDLO_WIDTH);

    typedef struct packed {
        logic                 pol;
        logic [EVT_IDX_W-1:0] idx;
    } edlo_evt_t;

endpackage

// File: rtl/edlo_evt_fifo.sv
// Synchronous event FIFO; push and pop may coincide at any occupancy.
// Latency: 1 cycle push-to-head, no empty bypass.
// Backpressure: caller must not push when full unless it pops in the same cycle.
module edlo_evt_fifo
    import edlo_pkg::*;
#(
    parameter int DEPTH = EDLO_FIFO_DEPTH
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_vld,
    input  edlo_evt_t push_dat,
    input  logic      pop_rdy,
    output logic      full,
    output logic      empty,
    output edlo_evt_t head_dat
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    edlo_evt_t     mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Head is forced to zero while empty so the stale slot never leaks out.
    assign head_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_vld) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_vld) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_rdy && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/edlo_input_conditioner.sv
// Synchronises and debounces raw pins, turning each accepted level change into a queued event.
// Latency: 2 sync + (DB_CYCLES-1)*PRESCALE+1..DB_CYCLES*PRESCALE debounce + 1 to evt_valid.
// Backpressure: evt_ready low holds events in FIFO then in the pending mask; re-flip while pending sets ovf.
module edlo_input_conditioner
    import edlo_pkg::*;
#(
    parameter int WIDTH      = EDLO_WIDTH,
    parameter int PRESCALE   = EDLO_PRESCALE,
    parameter int DB_CYCLES  = EDLO_DB_CYCLES,
    parameter int FIFO_DEPTH = EDLO_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic [WIDTH-1:0]           raw_in,
    output logic [WIDTH-1:0]           stable,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [$clog2(WIDTH):0]     evt_data,
    output logic                       ovf,
    input  logic                       ovf_clr
);

    localparam int IDX_W = EVT_IDX_W;
    localparam int PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CW    = $clog2(DB_CYCLES + 1);

    logic [WIDTH-1:0]          sync1;
    logic [WIDTH-1:0]          sync2;
    logic [PW-1:0]             pre;
    logic                      tick;
    logic [WIDTH-1:0][CW-1:0]  db_cnt;
    logic [WIDTH-1:0][CW-1:0]  db_cnt_nxt;
    logic [WIDTH-1:0]          stable_q;
    logic [WIDTH-1:0]          stable_nxt;
    logic [WIDTH-1:0]          flip;
    logic [WIDTH-1:0]          pend;
    logic                      pick_hit;
    logic [IDX_W-1:0]          pick_idx;
    logic [WIDTH-1:0]          push_mask;
    logic                      push_vld;
    logic                      pop_rdy;
    logic                      ovf_set;
    logic                      fifo_full;
    logic                      fifo_empty;
    edlo_evt_t                 push_dat;
    edlo_evt_t                 head_dat;

    assign tick = ena && (pre == PW'(PRESCALE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            pre   <= '0;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
            if (ena) begin
                pre <= (pre == PW'(PRESCALE - 1)) ? '0 : pre + 1'b1;
            end
        end
    end

    // Counter counts ticks on which the synced level disagrees; the final tick toggles the level.
    always_comb begin
        db_cnt_nxt = db_cnt;
        stable_nxt = stable_q;
        flip       = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (ena) begin
                if (sync2[i] == stable_q[i]) begin
                    db_cnt_nxt[i] = '0;
                end else if (tick) begin
                    if (db_cnt[i] == CW'(DB_CYCLES - 1)) begin
                        stable_nxt[i] = ~stable_q[i];
                        db_cnt_nxt[i] = '0;
                        flip[i]       = 1'b1;
                    end else begin
                        db_cnt_nxt[i] = db_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        pick_hit = 1'b0;
        pick_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pend[i]) begin
                pick_hit = 1'b1;
                pick_idx = IDX_W'(i);
            end
        end
    end

    assign pop_rdy   = evt_valid && evt_ready;
    assign push_vld  = pick_hit && (!fifo_full || pop_rdy);
    assign push_mask = push_vld ? (WIDTH'(1) << pick_idx) : '0;
    // A bit leaving pending this edge carries its old level out, so a new flip is not a loss.
    assign ovf_set   = |(flip & pend & ~push_mask);

    always_comb begin
        push_dat     = '0;
        push_dat.pol = stable_q[pick_idx];
        push_dat.idx = pick_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt   <= '0;
            stable_q <= '0;
            pend     <= '0;
            ovf      <= 1'b0;
        end else begin
            db_cnt   <= db_cnt_nxt;
            stable_q <= stable_nxt;
            pend     <= (pend & ~push_mask) | flip;
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    edlo_evt_fifo #(
        .DEPTH    (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_rdy  (pop_rdy),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head_dat (head_dat)
    );

    assign stable    = stable_q;
    assign evt_valid = !fifo_empty;
    assign evt_data  = head_dat;

endmodule

// File: tb/tb_edlo_input_conditioner.sv
// Randomised and directed bench for edlo_input_conditioner against a queue-based reference model.
module tb_edlo_input_conditioner;

    localparam int W  = 8;
    localparam int PS = 4;
    localparam int DB = 3;
    localparam int FD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] raw_in = 8'h00;
    logic       evt_ready = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [7:0] stable;
    logic       evt_valid;
    logic [3:0] evt_data;
    logic       ovf;

    edlo_input_conditioner #(
        .WIDTH      (W),
        .PRESCALE   (PS),
        .DB_CYCLES  (DB),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .raw_in     (raw_in),
        .stable     (stable),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_data   (evt_data),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: pins seen two edges late, ticks every PS-th enabled cycle,
    // a level is accepted after DB differing ticks, events kept in a plain queue.
    int         m_en_cycles;
    logic [7:0] m_s1, m_s, m_st, m_pend;
    int         m_cnt [8];
    logic [3:0] m_q [$];
    logic       m_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_en_cycles = 0;
            m_s1 = 8'h00; m_s = 8'h00; m_st = 8'h00; m_pend = 8'h00;
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
            automatic bit         pop   = (m_q.size() > 0) && evt_ready;
            automatic bit         tick  = ena && ((m_en_cycles % PS) == PS - 1);
            automatic logic [7:0] flips = 8'h00;
            automatic logic [7:0] pmask = 8'h00;
            automatic int         pj    = -1;
            automatic logic [3:0] pev   = 4'h0;
            for (int j = 0; j < 8; j++) if (m_pend[j] && pj < 0) pj = j;
            if (pj >= 0 && (m_q.size() < FD || pop)) begin
                pev   = {m_st[pj], 3'(pj)};
                pmask = 8'(1) << pj;
            end else begin
                pj = -1;
            end
            for (int i = 0; i < 8; i++) begin
                if (ena) begin
                    if (m_s[i] != m_st[i]) begin
                        if (tick) begin
                            m_cnt[i]++;
                            if (m_cnt[i] == DB) begin
                                flips[i] = 1'b1;
                                m_cnt[i] = 0;
                            end
                        end
                    end else begin
                        m_cnt[i] = 0;
                    end
                end
            end
            if ((flips & m_pend & ~pmask) != 8'h00) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            m_pend = (m_pend & ~pmask) | flips;
            m_st   = m_st ^ flips;
            if (pop) void'(m_q.pop_front());
            if (pj >= 0) m_q.push_back(pev);
            m_s  = m_s1;
            m_s1 = raw_in;
            if (ena) m_en_cycles++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("stable", stable, m_st);
            chk("evt_valid", evt_valid, m_q.size() > 0);
            if (m_q.size() > 0) chk("evt_data", evt_data, m_q[0]);
            chk("ovf", ovf, m_ovf);
        end
    end

    logic [3:0] got_d [$];
    int         got_c [$];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        raw_in = 8'h00; evt_ready = 1'b0; ovf_clr = 1'b0; ena = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        chk("rst_stable", stable, 8'h00);
        chk("rst_valid", evt_valid, 1'b0);
        chk("rst_data", evt_data, 4'h0);
        chk("rst_ovf", ovf, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic collect(input int n);
        got_d.delete();
        got_c.delete();
        for (int k = 0; k < n; k++) begin
            if (evt_valid && evt_ready) begin
                got_d.push_back(evt_data);
                got_c.push_back(k);
            end
            step(1);
        end
    endtask

    initial begin
        int n;
        int seen;
        int b6;

        // 1: single rise, latency window and event contents
        do_reset();
        raw_in[2] = 1'b1;
        n = 0;
        while (stable[2] == 1'b0 && n < 30) begin
            step(1);
            n++;
        end
        chk("t1_latency_in_9_12", (n - 2 >= 9) && (n - 2 <= 12), 1'b1);
        chk("t1_valid_not_yet", evt_valid, 1'b0);
        step(1);
        chk("t1_valid", evt_valid, 1'b1);
        chk("t1_data", evt_data, 4'b1010);

        // 2: 8-clock glitch is rejected
        do_reset();
        raw_in[5] = 1'b1;
        step(8);
        raw_in[5] = 1'b0;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            if (evt_valid) seen++;
            step(1);
        end
        chk("t2_stable", stable, 8'h00);
        chk("t2_no_event", seen, 0);
        chk("t2_ovf", ovf, 1'b0);

        // 3: two simultaneous rises, lowest index first, back to back
        do_reset();
        evt_ready = 1'b1;
        raw_in = 8'h81;
        collect(40);
        chk("t3_count", got_d.size(), 2);
        if (got_d.size() == 2) begin
            chk("t3_first", got_d[0], 4'b1000);
            chk("t3_second", got_d[1], 4'b1111);
            chk("t3_consecutive", got_c[1] - got_c[0], 1);
        end

        // 4: FIFO fills, two stay pending, then ordered drain
        do_reset();
        raw_in = 8'h3F;
        step(25);
        chk("t4_valid", evt_valid, 1'b1);
        chk("t4_head", evt_data, 4'b1000);
        chk("t4_ovf", ovf, 1'b0);
        evt_ready = 1'b1;
        collect(20);
        chk("t4_count", got_d.size(), 6);
        if (got_d.size() == 6) begin
            for (int k = 0; k < 6; k++) chk("t4_order", got_d[k], {1'b1, 3'(k)});
        end

        // 5: overflow on re-flip while pending, single surviving event
        do_reset();
        raw_in = 8'h0F;
        step(25);
        raw_in[6] = 1'b1;
        step(20);
        raw_in[6] = 1'b0;
        step(20);
        chk("t5_ovf_set", ovf, 1'b1);
        evt_ready = 1'b1;
        collect(20);
        chk("t5_count", got_d.size(), 5);
        b6 = 0;
        foreach (got_d[k]) if (got_d[k][2:0] == 3'd6) b6++;
        chk("t5_bit6_events", b6, 1);
        if (got_d.size() == 5) chk("t5_bit6_fall", got_d[4], 4'b0110);
        chk("t5_ovf_sticky", ovf, 1'b1);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        chk("t5_ovf_clr", ovf, 1'b0);

        // 6: reset mid-operation, then ena freeze, then pin held through reset
        do_reset();
        raw_in = 8'h03;
        step(25);
        chk("t6_two_queued", evt_valid, 1'b1);
        raw_in = 8'h07;
        step(6);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", evt_valid, 1'b0);
        chk("t6_rst_stable", stable, 8'h00);
        raw_in = 8'h00;
        @(posedge clk);
        #3 rst_n = 1'b1;
        step(1);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (evt_valid) seen++;
            step(1);
        end
        chk("t6_no_events", seen, 0);
        ena = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (k % 3 == 0) raw_in = 8'($urandom);
            step(1);
        end
        chk("t6_frozen", stable, 8'h00);
        ena = 1'b1;
        rst_n = 1'b0;
        raw_in = 8'h10;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step(1);
        evt_ready = 1'b1;
        collect(30);
        chk("t6_held_count", got_d.size(), 1);
        if (got_d.size() == 1) chk("t6_held_rise", got_d[0], 4'b1100);

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            if ($urandom_range(0, 11) == 0) raw_in[$urandom_range(0, 7)] ^= 1'b1;
            ena       = ($urandom_range(0, 7) != 0);
            evt_ready = ($urandom_range(0, 3) == 0) ? 1'b0 : ((c / 200) % 2 == 0);
            ovf_clr   = ($urandom_range(0, 31) == 0);
            step(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
